// File: rtl/ioreg_led_capture.sv
// Free-running counter with run enable and key-triggered MSB snapshot onto LEDs.
// Optional input debounce filter selected by defining IOREG_DEBOUNCE_EN.
module ioreg_led_capture #(
  parameter int LEDS_NR      = 6,
  parameter int CTR_W        = 26,
  parameter int INV_BTN      = 1,
  parameter int CAPTURE_MODE = 1,
  parameter int DEB_CYC      = 16
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               key_i,
  output logic [LEDS_NR-1:0] led,
  output logic [7:0]         cap_cnt_o
);

  localparam int SNAP_W = LEDS_NR - 1;

  // Button vectors: bit 1 = run, bit 0 = key.
  logic [1:0]         w_raw;
  logic [1:0]         r_sync0;
  logic [1:0]         r_sync1;
  logic [1:0]         w_filt;
  logic               w_run_s;
  logic               w_key_s;
  logic [1:0]         r_prime;
  logic               r_armed;
  logic               r_key_d;
  logic               w_press;
  logic               w_load;
  logic [CTR_W-1:0]   r_ctr;
  logic [SNAP_W-1:0]  r_snap;
  logic [7:0]         r_cap;
  logic [LEDS_NR-1:0] r_led;

  assign w_raw = {run_i, key_i} ^ ((INV_BTN != 0) ? 2'b11 : 2'b00);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
    end
  end

`ifdef IOREG_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYC + 1);

  logic [DCW-1:0] r_deb_cnt [2];
  logic [1:0]     r_filt;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_filt       <= '0;
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_filt[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DCW'(DEB_CYC - 1)) begin
          r_filt[i]    <= r_sync1[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  logic w_unused_deb;
  assign w_unused_deb = (DEB_CYC < 2);
  assign w_filt       = r_sync1;
`endif

  assign w_run_s = w_filt[1];
  assign w_key_s = w_filt[0];

  // A key held through reset release must be seen released at the synchroniser
  // output before any edge or level capture is honoured.
  assign w_press = w_key_s & ~r_key_d & r_armed;
  assign w_load  = (CAPTURE_MODE != 0) ? w_press : (w_key_s & r_armed);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_prime <= '0;
      r_armed <= 1'b0;
      r_key_d <= 1'b0;
      r_ctr   <= '0;
      r_snap  <= '0;
      r_cap   <= '0;
      r_led   <= '0;
    end else begin
      r_prime <= {r_prime[0], 1'b1};
      if (r_prime[1] && !r_sync1[0]) begin
        r_armed <= 1'b1;
      end
      r_key_d <= w_key_s;
      if (w_run_s) begin
        r_ctr <= r_ctr + CTR_W'(1);
      end
      if (w_load) begin
        r_snap <= r_ctr[CTR_W-2 -: SNAP_W];
      end
      if (w_press && (r_cap != 8'hFF)) begin
        r_cap <= r_cap + 8'd1;
      end
      r_led <= {r_ctr[CTR_W-1], r_snap};
    end
  end

  assign led       = r_led;
  assign cap_cnt_o = r_cap;

endmodule
